// File: rtl/pipe_cpu.sv
// pipe_cpu: 16-bit 5-stage in-order CPU with no interlocks, forwarding or flush.
// Software spaces dependent instructions; the coprocessor is reached through gr1..gr3 and LIOx.
module pipe_cpu #(
  parameter int GENERAL_REG_WIDTH = 16,
  parameter int ADDR_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         start,
  input  logic [GENERAL_REG_WIDTH-1:0] i_datain,
  output logic [ADDR_WIDTH-1:0]        i_addr,
  input  logic [GENERAL_REG_WIDTH-1:0] d_datain,
  output logic [ADDR_WIDTH-1:0]        d_addr,
  output logic                         d_we,
  output logic [GENERAL_REG_WIDTH-1:0] d_dataout,
  input  logic [GENERAL_REG_WIDTH-1:0] io_status,
  input  logic [GENERAL_REG_WIDTH-1:0] io_datainA,
  input  logic [GENERAL_REG_WIDTH-1:0] io_datainB,
  output logic [GENERAL_REG_WIDTH-1:0] io_control,
  output logic [GENERAL_REG_WIDTH-1:0] io_dataoutA,
  output logic [GENERAL_REG_WIDTH-1:0] io_dataoutB
);

  // state   | meaning
  // IDLE    | pc held, NOPs injected into ID, waiting for start
  // EXEC    | fetching one instruction per cycle
  // HALTED  | HALT reached ID; pc/id_ir frozen, later stages drain

  localparam int W = GENERAL_REG_WIDTH;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_SET   = 5'b10100;
  localparam logic [4:0] OP_LIOS  = 5'b10101;
  localparam logic [4:0] OP_LIOA  = 5'b10110;
  localparam logic [4:0] OP_LIOB  = 5'b10111;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  localparam logic [W-1:0] NOP_IR = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_next;
  logic   fetch_en, inject_nop;

  logic [ADDR_WIDTH-1:0] pc;
  logic [W-1:0] id_ir, ex_ir, mem_ir, wb_ir;
  logic [W-1:0] reg_A, reg_B, reg_C, reg_C1;
  logic [W-1:0] ex_sd, mem_sd;
  logic [W-1:0] gr [0:7];
  logic         zf, nf, cf;

  logic [4:0] id_op, ex_op, mem_op, wb_op;
  logic [2:0] id_r1, id_r2, id_r3, wb_r1;
  logic [7:0] id_imm;
  logic [3:0] id_val3;

  assign id_op   = id_ir[15:11];
  assign id_r1   = id_ir[10:8];
  assign id_r2   = id_ir[6:4];
  assign id_r3   = id_ir[2:0];
  assign id_imm  = id_ir[7:0];
  assign id_val3 = id_ir[3:0];
  assign ex_op   = ex_ir[15:11];
  assign mem_op  = mem_ir[15:11];
  assign wb_op   = wb_ir[15:11];
  assign wb_r1   = wb_ir[10:8];

  logic unused_bits;
  assign unused_bits = ^{ex_ir[10:0], mem_ir[10:0], wb_ir[7:0]};

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= IDLE;
    else if (enable) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXEC;
      EXEC:    if (id_op == OP_HALT) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_en   = 1'b0;
    inject_nop = 1'b0;
    case (state)
      IDLE:    inject_nop = 1'b1;
      EXEC:    fetch_en   = (id_op != OP_HALT);
      default: ;
    endcase
  end

  // ---------------- WB / register file ----------------
  logic wb_writes, wb_we;

  always_comb begin
    case (wb_op)
      OP_LOAD, OP_SLL, OP_SRL, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
      OP_AND, OP_OR, OP_XOR, OP_SET, OP_LIOS, OP_LIOA, OP_LIOB: wb_writes = 1'b1;
      default: wb_writes = 1'b0;
    endcase
  end

  assign wb_we = wb_writes && (wb_r1 != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) gr[i] <= '0;
    end else if (enable && wb_we) begin
      gr[wb_r1] <= reg_C1;
    end
  end

  // ID reads see a write landing on the same edge
  logic [W-1:0] rd_r1, rd_r2, rd_r3;

  always_comb begin
    rd_r1 = (wb_we && wb_r1 == id_r1) ? reg_C1 : gr[id_r1];
    rd_r2 = (wb_we && wb_r1 == id_r2) ? reg_C1 : gr[id_r2];
    rd_r3 = (wb_we && wb_r1 == id_r3) ? reg_C1 : gr[id_r3];
  end

  // ---------------- ID operand select ----------------
  logic [W-1:0] opa, opb;

  always_comb begin
    opa = '0;
    opb = '0;
    case (id_op)
      OP_LOAD, OP_STORE, OP_SLL, OP_SRL: begin
        opa = rd_r2;
        opb = {{(W-4){1'b0}}, id_val3};
      end
      OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
        opa = rd_r2;
        opb = rd_r3;
      end
      OP_ADDI, OP_SUBI, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
        opa = rd_r1;
        opb = {{(W-8){1'b0}}, id_imm};
      end
      OP_SET, OP_JUMP: opb = {{(W-8){1'b0}}, id_imm};
      default: ;
    endcase
  end

  // ---------------- EX ----------------
  logic [W:0]   sum_x, diff_x;
  logic [W-1:0] alu_res;
  logic         alu_carry, flag_upd;

  assign sum_x  = {1'b0, reg_A} + {1'b0, reg_B};
  assign diff_x = {1'b0, reg_A} - {1'b0, reg_B};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    flag_upd  = 1'b0;
    case (ex_op)
      OP_LOAD, OP_STORE, OP_SET, OP_JUMP,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: alu_res = sum_x[W-1:0];
      OP_ADD, OP_ADDI: begin
        alu_res   = sum_x[W-1:0];
        alu_carry = sum_x[W];
        flag_upd  = 1'b1;
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        alu_res   = diff_x[W-1:0];
        alu_carry = diff_x[W];
        flag_upd  = 1'b1;
      end
      OP_AND: begin alu_res = reg_A & reg_B;        flag_upd = 1'b1; end
      OP_OR:  begin alu_res = reg_A | reg_B;        flag_upd = 1'b1; end
      OP_XOR: begin alu_res = reg_A ^ reg_B;        flag_upd = 1'b1; end
      OP_SLL: begin alu_res = reg_A << reg_B[3:0];  flag_upd = 1'b1; end
      OP_SRL: begin alu_res = reg_A >> reg_B[3:0];  flag_upd = 1'b1; end
      OP_LIOS: alu_res = io_status;
      OP_LIOA: alu_res = io_datainA;
      OP_LIOB: alu_res = io_datainB;
      default: ;
    endcase
  end

  // ---------------- MEM branch resolution ----------------
  logic br_taken;

  always_comb begin
    case (mem_op)
      OP_JUMP: br_taken = 1'b1;
      OP_BZ:   br_taken = zf;
      OP_BNZ:  br_taken = !zf;
      OP_BN:   br_taken = nf;
      OP_BNN:  br_taken = !nf;
      OP_BC:   br_taken = cf;
      OP_BNC:  br_taken = !cf;
      default: br_taken = 1'b0;
    endcase
  end

  // ---------------- front end ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      id_ir <= NOP_IR;
    end else if (enable) begin
      if (inject_nop) begin
        id_ir <= NOP_IR;
      end else if (fetch_en) begin
        id_ir <= i_datain;
        pc    <= br_taken ? reg_C[ADDR_WIDTH-1:0]
                          : pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ir  <= NOP_IR;
      mem_ir <= NOP_IR;
      wb_ir  <= NOP_IR;
      reg_A  <= '0;
      reg_B  <= '0;
      reg_C  <= '0;
      reg_C1 <= '0;
      ex_sd  <= '0;
      mem_sd <= '0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
    end else if (enable) begin
      ex_ir  <= id_ir;
      reg_A  <= opa;
      reg_B  <= opb;
      ex_sd  <= rd_r1;
      mem_ir <= ex_ir;
      reg_C  <= alu_res;
      mem_sd <= ex_sd;
      wb_ir  <= mem_ir;
      reg_C1 <= (mem_op == OP_LOAD) ? d_datain : reg_C;
      if (flag_upd) begin
        zf <= (alu_res == '0);
        nf <= alu_res[W-1];
        cf <= alu_carry;
      end
    end
  end

  assign i_addr      = pc;
  assign d_addr      = reg_C[ADDR_WIDTH-1:0];
  assign d_we        = (mem_op == OP_STORE);
  assign d_dataout   = mem_sd;
  assign io_control  = gr[1];
  assign io_dataoutA = gr[2];
  assign io_dataoutB = gr[3];

endmodule

// File: tb/tb_pipe_cpu.sv
// Directed bench for pipe_cpu: small programs in a behavioural instruction/data memory,
// results checked against hand-computed register, memory and flag values.
module tb_pipe_cpu;

  logic        clk = 1'b0;
  logic        rst_n, enable, start;
  logic [15:0] i_datain, d_datain, d_dataout;
  logic [7:0]  i_addr, d_addr;
  logic        d_we;
  logic [15:0] io_status, io_datainA, io_datainB;
  logic [15:0] io_control, io_dataoutA, io_dataoutB;

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:255];
  logic        clr, done_en;
  int          bnz_cnt, we_cnt;
  int          errors = 0;
  int          checks = 0;

  localparam logic [4:0] NOP = 5'b00000, HALT = 5'b00001, LOAD = 5'b00010, STORE = 5'b00011;
  localparam logic [4:0] ADDI = 5'b01001, SUB = 5'b01010, SUBI = 5'b01011, CMP = 5'b01100;
  localparam logic [4:0] SET = 5'b10100, LIOS = 5'b10101, LIOA = 5'b10110, LIOB = 5'b10111;
  localparam logic [4:0] JUMP = 5'b11000, BZ = 5'b11010, BNZ = 5'b11011;

  always #5 clk = ~clk;

  pipe_cpu dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .i_datain(i_datain), .i_addr(i_addr),
    .d_datain(d_datain), .d_addr(d_addr), .d_we(d_we), .d_dataout(d_dataout),
    .io_status(io_status), .io_datainA(io_datainA), .io_datainB(io_datainB),
    .io_control(io_control), .io_dataoutA(io_dataoutA), .io_dataoutB(io_dataoutB)
  );

  assign i_datain   = imem[i_addr];
  assign d_datain   = dmem[d_addr];
  assign io_datainA = 16'h0123;
  assign io_datainB = 16'h0456;
  // coprocessor reports done only once the fifth loop-closing branch has been fetched
  assign io_status  = {15'h0, done_en && (bnz_cnt >= 5)};

  always @(posedge clk) begin
    if (clr) begin
      dmem[0] <= 16'h00AB;
      dmem[2] <= 16'h0000;
    end else if (d_we) begin
      dmem[d_addr] <= d_dataout;
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      bnz_cnt = 0;
      we_cnt  = 0;
    end else if (rst_n && enable) begin
      if (i_addr == 8'd13) bnz_cnt = bnz_cnt + 1;
      if (d_we) we_cnt = we_cnt + 1;
    end
  end

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] r1, input logic [7:0] imm);
    return {op, r1, imm};
  endfunction

  function automatic logic [15:0] rrr(input logic [4:0] op, input logic [2:0] r1,
                                      input logic [2:0] r2, input logic [2:0] r3);
    return {op, r1, 1'b0, r2, 1'b0, r3};
  endfunction

  function automatic logic [15:0] mop(input logic [4:0] op, input logic [2:0] r1,
                                      input logic [2:0] r2, input logic [3:0] v3);
    return {op, r1, 1'b0, r2, v3};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b1;
    tick(2);
    rst_n = 1'b1;
    clr   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic load_poll();
    clear_imem();
    imem[0]  = ins(SET, 3'd6, 8'd1);
    imem[1]  = ins(SET, 3'd7, 8'd12);
    imem[3]  = ins(LIOS, 3'd5, 8'd0);
    imem[7]  = rrr(CMP, 3'd0, 3'd5, 3'd6);
    imem[8]  = ins(BZ, 3'd0, 8'd23);
    imem[12] = ins(SUBI, 3'd7, 8'd1);
    imem[13] = ins(BNZ, 3'd0, 8'd3);
    imem[17] = ins(HALT, 3'd0, 8'd0);
    imem[23] = ins(LIOA, 3'd2, 8'd0);
    imem[24] = ins(LIOB, 3'd3, 8'd0);
    imem[28] = ins(HALT, 3'd0, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; clr = 1'b1; done_en = 1'b0;
    clear_imem();
    imem[0] = ins(SET, 3'd1, 8'h24);
    imem[4] = ins(HALT, 3'd0, 8'd0);
    tick(2);

    // reset state
    check("rst_pc", {8'h00, i_addr}, 16'h0000);
    check("rst_id_ir", dut.id_ir, 16'h0000);
    check("rst_reg_C", dut.reg_C, 16'h0000);
    check("rst_reg_C1", dut.reg_C1, 16'h0000);
    check("rst_io_control", io_control, 16'h0000);
    check("rst_io_dataoutA", io_dataoutA, 16'h0000);
    check("rst_io_dataoutB", io_dataoutB, 16'h0000);
    check("rst_d_we", {15'h0, d_we}, 16'h0000);
    check("rst_flags", {13'h0, dut.zf, dut.nf, dut.cf}, 16'h0000);

    // no start pulse: nothing runs
    rst_n = 1'b1; clr = 1'b0;
    tick(10);
    check("nostart_pc", {8'h00, i_addr}, 16'h0000);
    check("nostart_gr1", dut.gr[1], 16'h0000);

    // SET gr1,0x24 then HALT
    pulse_start();
    tick(20);
    check("set_io_control", io_control, 16'h0024);
    check("halt_pc", {8'h00, i_addr}, 16'h0005);
    tick(5);
    check("halt_pc_frozen", {8'h00, i_addr}, 16'h0005);

    // async reset while looping
    do_reset();
    imem[4] = ins(JUMP, 3'd0, 8'd0);
    pulse_start();
    tick(15);
    check("loop_io_control", io_control, 16'h0024);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_io_control", io_control, 16'h0000);
    check("midreset_pc", {8'h00, i_addr}, 16'h0000);
    tick(1);
    rst_n = 1'b1;

    // LOAD / ADDI / STORE
    do_reset();
    clear_imem();
    imem[0]  = mop(LOAD, 3'd4, 3'd0, 4'd0);
    imem[4]  = ins(ADDI, 3'd4, 8'd1);
    imem[8]  = mop(STORE, 3'd4, 3'd0, 4'd2);
    imem[12] = ins(HALT, 3'd0, 8'd0);
    pulse_start();
    tick(30);
    check("ls_gr4", dut.gr[4], 16'h00AC);
    check("ls_dmem2", dmem[2], 16'h00AC);
    check("ls_dmem0", dmem[0], 16'h00AB);
    check("ls_we_cycles", we_cnt[15:0], 16'd1);

    // SUB with borrow
    do_reset();
    clear_imem();
    imem[0] = ins(SET, 3'd2, 8'hFF);
    imem[4] = rrr(SUB, 3'd3, 3'd0, 3'd2);
    imem[8] = ins(HALT, 3'd0, 8'd0);
    pulse_start();
    tick(25);
    check("sub_gr3", dut.gr[3], 16'hFF01);
    check("sub_nf", {15'h0, dut.nf}, 16'd1);
    check("sub_cf", {15'h0, dut.cf}, 16'd1);
    check("sub_zf", {15'h0, dut.zf}, 16'd0);

    // poll loop, done rises after five polls
    do_reset();
    load_poll();
    done_en = 1'b1;
    pulse_start();
    tick(250);
    check("poll_gr2", dut.gr[2], 16'h0123);
    check("poll_gr3", dut.gr[3], 16'h0456);
    check("poll_io_dataoutA", io_dataoutA, 16'h0123);
    check("poll_gr5", dut.gr[5], 16'h0001);
    check("poll_gr7", dut.gr[7], 16'h0007);
    check("poll_iterations", bnz_cnt[15:0], 16'd5);
    check("poll_pc", {8'h00, i_addr}, 16'd29);

    // poll loop, done never set, with a 5-cycle stall
    do_reset();
    done_en = 1'b0;
    pulse_start();
    tick(10);
    check("prestall_pc", {8'h00, i_addr}, 16'd10);
    enable = 1'b0;
    tick(5);
    check("stall_pc", {8'h00, i_addr}, 16'd10);
    check("stall_gr7", dut.gr[7], 16'd12);
    enable = 1'b1;
    tick(300);
    check("nodone_gr7", dut.gr[7], 16'h0000);
    check("nodone_zf", {15'h0, dut.zf}, 16'd1);
    check("nodone_cf", {15'h0, dut.cf}, 16'd0);
    check("nodone_gr5", dut.gr[5], 16'h0000);
    check("nodone_iterations", bnz_cnt[15:0], 16'd12);
    check("nodone_pc", {8'h00, i_addr}, 16'd18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
